// File: rtl/gcd_pkg.sv
// rtl/gcd_pkg.sv - shared state encoding and default parameters for the GCD sequencer
package gcd_pkg;

  localparam int GCD_WIDTH_DEF   = 16;
  localparam int GCD_TIMEOUT_DEF = 70000;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOAD_A = 3'd1;
  localparam logic [2:0] ST_LOAD_B = 3'd2;
  localparam logic [2:0] ST_WAIT   = 3'd3;
  localparam logic [2:0] ST_CLEAR  = 3'd4;
  localparam logic [2:0] ST_RESP   = 3'd5;

  // Counter width for a given WAIT budget; never narrower than one bit
  function automatic int ctr_width(input int timeout);
    return (timeout > 1) ? $clog2(timeout) : 1;
  endfunction

endpackage

// File: rtl/gcd_timeout_ctr.sv
// rtl/gcd_timeout_ctr.sv - WAIT-state cycle counter with expiry flag
module gcd_timeout_ctr
  import gcd_pkg::*;
#(
  parameter int TIMEOUT = GCD_TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int            CW   = ctr_width(TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] count;

  // Count WAIT cycles from zero; hold at the last value so it can never wrap
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != LAST)) begin
      count <= count + CW'(1);
    end
  end

  assign expired = (count == LAST);

endmodule

// File: rtl/gcd_sequencer.sv
// rtl/gcd_sequencer.sv - drives an external GCD core through load, wait, clear and response
module gcd_sequencer
  import gcd_pkg::*;
#(
  parameter int WIDTH   = GCD_WIDTH_DEF,
  parameter int TIMEOUT = GCD_TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_err,
  output logic             gcd_start,
  output logic [WIDTH-1:0] gcd_data,
  output logic             gcd_rst,
  input  logic             gcd_done,
  input  logic [WIDTH-1:0] gcd_result,
  output logic             busy
);

  logic [2:0]       state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             expired;
  logic             accept;
  logic             in_wait;

  // in_ready is masked by rst so nothing is offered while reset is held
  assign in_ready  = (state == ST_IDLE) && !rst;
  assign accept    = in_valid && in_ready;
  assign in_wait   = (state == ST_WAIT);
  assign busy      = (state != ST_IDLE);
  assign out_valid = (state == ST_RESP);
  assign gcd_start = (state == ST_LOAD_A);
  assign gcd_rst   = rst || (state == ST_CLEAR);

  gcd_timeout_ctr #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout_ctr (
    .clk    (clk),
    .rst    (rst),
    .clear  (!in_wait),
    .enable (in_wait),
    .expired(expired)
  );

  // Operand bus carries A then B on the two load cycles, zero otherwise
  always_comb begin
    gcd_data = '0;
    if (state == ST_LOAD_A) begin
      gcd_data = a_q;
    end else if (state == ST_LOAD_B) begin
      gcd_data = b_q;
    end
  end

  // Sequencer FSM plus operand and response registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      a_q        <= '0;
      b_q        <= '0;
      out_result <= '0;
      out_err    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            a_q <= in_a;
            b_q <= in_b;
            // A zero operand makes the answer the other operand; skip the core
            if ((in_a == '0) || (in_b == '0)) begin
              out_result <= in_a | in_b;
              out_err    <= 1'b0;
              state      <= ST_RESP;
            end else begin
              state <= ST_LOAD_A;
            end
          end
        end
        ST_LOAD_A: state <= ST_LOAD_B;
        ST_LOAD_B: state <= ST_WAIT;
        ST_WAIT: begin
          // done is checked first so it wins over a same-cycle expiry
          if (gcd_done) begin
            out_result <= gcd_result;
            out_err    <= 1'b0;
            state      <= ST_CLEAR;
          end else if (expired) begin
            out_result <= '0;
            out_err    <= 1'b1;
            state      <= ST_CLEAR;
          end
        end
        ST_CLEAR: state <= ST_RESP;
        ST_RESP: begin
          if (out_ready) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gcd_sequencer.sv
// tb/tb_gcd_sequencer.sv - scoreboard bench for gcd_sequencer with a subtractive core model
module tb_gcd_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sel = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [15:0] in_a = 16'd0;
  logic [15:0] in_b = 16'd0;

  logic        a_in_valid, a_in_ready, a_out_valid, a_out_err, a_gcd_start, a_gcd_rst, a_busy;
  logic [15:0] a_out_result, a_gcd_data;
  logic        core_done;
  logic [15:0] core_res;

  logic        t_in_valid, t_in_ready, t_out_valid, t_out_err, t_gcd_start, t_gcd_rst, t_busy;
  logic [15:0] t_out_result, t_gcd_data;
  logic        t_done = 1'b0;
  logic [15:0] t_core_res = 16'h00A5;

  logic        m_in_ready, m_out_valid, m_out_err, m_gcd_start, m_gcd_rst, m_busy;
  logic [15:0] m_out_result, m_gcd_data;

  int errors = 0;
  int checks = 0;
  logic [16:0] exp_q[$];

  always #5 clk = ~clk;

  assign a_in_valid = in_valid && !sel;
  assign t_in_valid = in_valid && sel;

  gcd_sequencer dut (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_a(in_a), .in_b(in_b), .out_valid(a_out_valid), .out_ready(out_ready),
    .out_result(a_out_result), .out_err(a_out_err), .gcd_start(a_gcd_start),
    .gcd_data(a_gcd_data), .gcd_rst(a_gcd_rst), .gcd_done(core_done),
    .gcd_result(core_res), .busy(a_busy)
  );

  gcd_sequencer #(.TIMEOUT(50)) dut_to (
    .clk(clk), .rst(rst), .in_valid(t_in_valid), .in_ready(t_in_ready),
    .in_a(in_a), .in_b(in_b), .out_valid(t_out_valid), .out_ready(out_ready),
    .out_result(t_out_result), .out_err(t_out_err), .gcd_start(t_gcd_start),
    .gcd_data(t_gcd_data), .gcd_rst(t_gcd_rst), .gcd_done(t_done),
    .gcd_result(t_core_res), .busy(t_busy)
  );

  assign m_in_ready   = sel ? t_in_ready   : a_in_ready;
  assign m_out_valid  = sel ? t_out_valid  : a_out_valid;
  assign m_out_err    = sel ? t_out_err    : a_out_err;
  assign m_out_result = sel ? t_out_result : a_out_result;
  assign m_gcd_start  = sel ? t_gcd_start  : a_gcd_start;
  assign m_gcd_data   = sel ? t_gcd_data   : a_gcd_data;
  assign m_gcd_rst    = sel ? t_gcd_rst    : a_gcd_rst;
  assign m_busy       = sel ? t_busy       : a_busy;

  // Subtractive GCD core: load A on start, B next cycle, then reduce until equal
  logic [15:0] ca, cb;
  logic [1:0]  cph;
  always @(posedge clk) begin
    if (a_gcd_rst) begin
      ca <= 16'd0; cb <= 16'd0; cph <= 2'd0;
    end else if (a_gcd_start) begin
      ca <= a_gcd_data; cph <= 2'd1;
    end else if (cph == 2'd1) begin
      cb <= a_gcd_data; cph <= 2'd2;
    end else if (cph == 2'd2 && ca != cb) begin
      if (ca > cb) ca <= ca - cb;
      else cb <= cb - ca;
    end
  end
  assign core_done = (cph == 2'd2) && (ca == cb);
  assign core_res  = ca;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  function automatic void fail_bound(input string name);
    checks++;
    errors++;
    $display("FAIL %s: bound expired", name);
  endfunction

  // Monitor: every accepted response is compared against the oldest expectation
  initial begin
    logic [16:0] e;
    forever begin
      @(negedge clk);
      #1;
      if (m_out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          fail_bound("unexpected_output");
        end else begin
          e = exp_q.pop_front();
          chk("result", 32'(m_out_result), 32'(e[15:0]));
          chk("err", 32'(m_out_err), 32'(e[16]));
        end
      end
    end
  end

  task automatic run_pair(input bit s, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] er, input bit ee, input int elat, input bit hold);
    int w;
    int lat;
    int starts;
    int rsts;
    bit seen;
    bit ok;
    logic [15:0] d1, d2, r0;
    logic e0;
    sel = s;
    out_ready = !hold;
    w = 0;
    @(negedge clk);
    while (!m_in_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!m_in_ready) fail_bound("in_ready_wait");
    in_a = a;
    in_b = b;
    in_valid = 1'b1;
    exp_q.push_back({ee, er});
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0; starts = 0; rsts = 0; seen = 1'b0; d1 = 16'd0; d2 = 16'd0;
    while (!seen && lat < 80000) begin
      @(negedge clk);
      lat++;
      if (m_out_valid) begin
        seen = 1'b1;
      end else begin
        if (m_gcd_start) starts++;
        if (m_gcd_rst) rsts++;
        if (lat == 1) d1 = m_gcd_data;
        if (lat == 2) d2 = m_gcd_data;
      end
    end
    if (!seen) fail_bound("out_valid_wait");
    chk("latency", 32'(lat), 32'(elat));
    if (a == 16'd0 || b == 16'd0) begin
      chk("bypass_starts", 32'(starts), 32'd0);
      chk("bypass_rsts", 32'(rsts), 32'd0);
    end else begin
      chk("start_pulses", 32'(starts), 32'd1);
      chk("data_a", 32'(d1), 32'(a));
      chk("data_b", 32'(d2), 32'(b));
      chk("clear_pulses", 32'(rsts), 32'd1);
    end
    if (hold) begin
      r0 = m_out_result;
      e0 = m_out_err;
      ok = 1'b1;
      repeat (10) begin
        @(negedge clk);
        if (!(m_out_valid && m_out_result == r0 && m_out_err == e0 && !m_in_ready)) ok = 1'b0;
      end
      chk("hold_stable", 32'(ok), 32'd1);
      @(posedge clk);
      #1 out_ready = 1'b1;
      @(negedge clk);
    end
    @(negedge clk);
    chk("idle_after_resp", 32'(m_in_ready), 32'd1);
    chk("valid_dropped", 32'(m_out_valid), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(a_in_ready), 32'd0);
    chk("rst_out_valid", 32'(a_out_valid), 32'd0);
    chk("rst_out_result", 32'(a_out_result), 32'd0);
    chk("rst_out_err", 32'(a_out_err), 32'd0);
    chk("rst_gcd_start", 32'(a_gcd_start), 32'd0);
    chk("rst_gcd_data", 32'(a_gcd_data), 32'd0);
    chk("rst_gcd_rst", 32'(a_gcd_rst), 32'd1);
    chk("rst_busy", 32'(a_busy), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(a_in_ready), 32'd1);

    run_pair(1'b0, 16'd12, 16'd18, 16'd6, 1'b0, 7, 1'b0);
    run_pair(1'b0, 16'd0, 16'd7, 16'd7, 1'b0, 1, 1'b0);
    run_pair(1'b0, 16'd0, 16'd0, 16'd0, 1'b0, 1, 1'b0);
    run_pair(1'b0, 16'd7, 16'd0, 16'd7, 1'b0, 1, 1'b0);
    run_pair(1'b0, 16'd21, 16'd14, 16'd7, 1'b0, 7, 1'b1);

    // Reset while the core is grinding through a long reduction
    sel = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("pre_mid_in_ready", 32'(a_in_ready), 32'd1);
    in_a = 16'd1;
    in_b = 16'd1000;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (6) @(negedge clk);
    chk("mid_busy", 32'(a_busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_gcd_rst", 32'(a_gcd_rst), 32'd1);
    chk("mid_out_valid", 32'(a_out_valid), 32'd0);
    chk("mid_busy_rst", 32'(a_busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_in_ready", 32'(a_in_ready), 32'd1);
    chk("mid_no_output", 32'(a_out_valid), 32'd0);
    run_pair(1'b0, 16'd9, 16'd6, 16'd3, 1'b0, 7, 1'b0);

    run_pair(1'b0, 16'd1, 16'd65535, 16'd1, 1'b0, 65539, 1'b0);

    run_pair(1'b1, 16'd5, 16'd7, 16'd0, 1'b1, 54, 1'b0);

    repeat (2) @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
